// File: rtl/regfile_write_arbiter_if.sv
// regfile_write_arbiter_if: writeback requests, grants, clear control and register-file write bus
// master drives valid/index/data and clear_req; slave (the arbiter) drives readies, clear_busy, rf_*
interface regfile_write_arbiter_if;
  logic        alu_valid;
  logic [4:0]  alu_index;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        mem_valid;
  logic [4:0]  mem_index;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic        lnk_valid;
  logic [31:0] lnk_data;
  logic        lnk_ready;
  logic        clear_req;
  logic        clear_busy;
  logic [1:0]  rf_write;
  logic [4:0]  rf_index;
  logic [31:0] rf_data;
  modport master (
    output alu_valid, alu_index, alu_data, mem_valid, mem_index, mem_data,
           lnk_valid, lnk_data, clear_req,
    input  alu_ready, mem_ready, lnk_ready, clear_busy, rf_write, rf_index, rf_data
  );
  modport slave (
    input  alu_valid, alu_index, alu_data, mem_valid, mem_index, mem_data,
           lnk_valid, lnk_data, clear_req,
    output alu_ready, mem_ready, lnk_ready, clear_busy, rf_write, rf_index, rf_data
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: arbitrates ALU/load/link writebacks onto one register-file write port, with a 32-cycle zero-fill sweep
// ports: clk, rst (sync, active high); bus (slave modport) carries requests/readies, clear_req/clear_busy, rf_write/rf_index/rf_data
// RR_ARB_EN defined: round-robin mem->alu->lnk; undefined: fixed priority mem > alu > lnk
module regfile_write_arbiter (
  input logic clk,
  input logic rst,
  regfile_write_arbiter_if.slave bus
);
  typedef enum logic {ARB, CLEAR} state_t;
  state_t state, state_n;
  logic [4:0] cnt, cnt_n;
  logic [1:0] wr, wr_n;
  logic [4:0] idx, idx_n;
  logic [31:0] dat, dat_n;
  logic [2:0] req, gnt, rdy;
  logic arb_open;
  assign req = {bus.lnk_valid, bus.alu_valid, bus.mem_valid};
  assign arb_open = state == ARB && !bus.clear_req && !rst;
`ifdef RR_ARB_EN
  logic [1:0] ptr, ptr_n;
  logic [2:0] rot, pick;
  // rotate so the pointed-to requester sits in bit 0, pick lowest, rotate back
  assign rot = ptr == 2'd0 ? req : ptr == 2'd1 ? {req[0], req[2:1]} : {req[1:0], req[2]};
  assign pick = rot[0] ? 3'b001 : rot[1] ? 3'b010 : rot[2] ? 3'b100 : 3'b000;
  assign gnt = ptr == 2'd0 ? pick : ptr == 2'd1 ? {pick[1:0], pick[2]} : {pick[0], pick[2:1]};
  assign ptr_n = rdy[0] ? 2'd1 : rdy[1] ? 2'd2 : rdy[2] ? 2'd0 : ptr;
  always_ff @(posedge clk)
    ptr <= rst ? 2'd0 : ptr_n;
`else
  assign gnt = req[0] ? 3'b001 : req[1] ? 3'b010 : req[2] ? 3'b100 : 3'b000;
`endif
  assign rdy = arb_open ? gnt : 3'b000;
  assign bus.mem_ready = rdy[0];
  assign bus.alu_ready = rdy[1];
  assign bus.lnk_ready = rdy[2];
  assign bus.clear_busy = state == CLEAR;
  assign bus.rf_write = wr;
  assign bus.rf_index = idx;
  assign bus.rf_data = dat;
  // rf_* registered so each CLEAR cycle shows the counter's own index
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    wr_n = 2'b00;
    idx_n = idx;
    dat_n = dat;
    if (state == CLEAR) begin
      cnt_n = cnt + 5'd1;
      state_n = cnt == 5'd31 ? ARB : CLEAR;
      if (cnt != 5'd31) begin
        wr_n = 2'b10;
        idx_n = cnt + 5'd1;
        dat_n = '0;
      end
    end else if (bus.clear_req) begin
      state_n = CLEAR;
      wr_n = 2'b10;
      idx_n = '0;
      dat_n = '0;
    end else if (rdy[0]) begin
      wr_n = 2'b10;
      idx_n = bus.mem_index;
      dat_n = bus.mem_data;
    end else if (rdy[1]) begin
      wr_n = 2'b10;
      idx_n = bus.alu_index;
      dat_n = bus.alu_data;
    end else if (rdy[2]) begin
      wr_n = 2'b01;
      idx_n = 5'd31;
      dat_n = bus.lnk_data;
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= ARB;
      cnt <= '0;
      wr <= '0;
      idx <= '0;
      dat <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      wr <= wr_n;
      idx <= idx_n;
      dat <= dat_n;
    end
endmodule
